tmr_coder_pipe: RTL and testbench
=================================

Name: tmr_coder_pipe

Overview:
- Parametrised successor to the fixed 16-bit, triple-copy TMR encoder.
- Accepts DATA_W-bit words over a valid/ready handshake and emits COPIES concatenated replicas per word.
- Uses a 2-entry elastic buffer so back-pressure from the channel/voter side never drops or duplicates words.
- Adds a per-word bypass mode (single copy, other lanes zeroed) for power comparison against full TMR, and a transfer counter for power-evaluation runs.

Parameters:
- DATA_W, 16, payload width in bits; ≥1.
- COPIES, 3, replica count; odd and ≥3, any other value is an elaboration error.
- CNT_W, 16, width of word_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  payload.
- in_bypass  input  1  sampled with in_data: 0 = replicate, 1 = bypass.
- out_valid  output  1  encoded word present.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W*COPIES  encoded word; copy k occupies bits [k*DATA_W +: DATA_W].
- word_count  output  CNT_W  completed output transfers, modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=EMPTY, out_valid=0, out_data=0, word_count=0, both buffer entries cleared.
  - Handshakes in the same cycle as reset are discarded: nothing accepted, nothing counted.
  - A reset asserted mid-operation drops buffered words.
- Transfer definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Buffer: a 2-entry FIFO (head, tail) that stores {in_data, in_bypass}. Encoding is combinational from head.
- State machine (registered):
  - EMPTY: accept -> ONE (word goes to head).
  - ONE:
    - accept & !pop -> TWO (word goes to tail).
    - pop & !accept -> EMPTY.
    - accept & pop -> ONE (head takes the new word).
    - neither -> ONE.
  - TWO: in_ready=0; pop -> ONE (tail moves to head); otherwise hold.
- Ready/valid decode:
  - in_ready = (state != TWO), decoded from registered state only, with no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- Latency: a word accepted at edge N appears at out_valid/out_data after edge N (1 cycle) when the buffer was EMPTY.
  - Sustained throughput is 1 word/cycle while out_ready=1.
- Ordering is strict FIFO; no loss or duplication under any valid/ready pattern.
- Encoding of head:
  - bypass=0: all COPIES lanes equal to data.
  - bypass=1: lane 0 = data, lanes 1..COPIES-1 = 0.
- When out_valid=0, out_data holds its last value (0 after reset).
- While out_valid=1 & out_ready=0, out_data is stable.
- word_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- in_valid is allowed to drop without a transfer; the block has no assumption on upstream stability.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with in_valid=1 -> after release out_valid=0, out_data=0, word_count=0, in_ready=1; no word emitted.
- Single word, DATA_W=16, COPIES=3: in_data=16'hA5C3, bypass=0, out_ready=1 -> next cycle out_data=48'hA5C3_A5C3_A5C3, out_valid for 1 cycle, word_count=1.
- Bypass: in_data=16'h1234, bypass=1 -> out_data=48'h0000_0000_1234.
- Back-pressure: out_ready=0, send 16'h0001, 16'h0002 -> in_ready=0 after the second accept, a third word is held off. Then raise out_ready -> outputs 0001, 0002, 0003 in order, each tripled, word_count=3.
- Streaming with random out_ready (1000 words, random bypass) -> scoreboard matches order and encoding; word_count equals the pop count mod 2^CNT_W. With CNT_W=4, the 17th pop shows word_count=1.
- Reset mid-operation: buffer in TWO, pulse rst_n=0 for 1 cycle -> state EMPTY, out_valid=0, word_count=0, buffered words not emitted; COPIES=5, DATA_W=8 repeated with in_data=8'h3C -> out_data=40'h3C3C3C3C3C.

Source files
------------

// File: rtl/tmr_coder_pipe.sv
// Purpose: replicates each DATA_W-bit word COPIES times (or one lane only in bypass) for TMR channels.
// Latency: 1 cycle from accept to out_valid when empty; sustains 1 word/cycle with out_ready high.
// Backpressure: 2-entry elastic buffer; in_ready depends only on registered state, never on out_ready.
module tmr_coder_pipe #(
  parameter int DATA_W = 16,
  parameter int COPIES = 3,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_bypass,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W*COPIES-1:0] out_data,
  output logic [CNT_W-1:0]         word_count
);

  // Majority voting downstream needs an odd replica count of at least three.
  if ((COPIES < 3) || ((COPIES % 2) == 0)) begin : g_bad_copies
    $error("tmr_coder_pipe: COPIES must be odd and >= 3");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("tmr_coder_pipe: DATA_W must be >= 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   head_dat;
  logic                head_byp;
  logic [DATA_W-1:0]   tail_dat;
  logic                tail_byp;
  logic                accept;
  logic                pop;

  // Handshake decode purely from registered state keeps timing paths short.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Buffer occupancy FSM plus transfer counter; head is left untouched on
  // drain so out_data keeps its last value while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      head_dat   <= '0;
      head_byp   <= 1'b0;
      tail_dat   <= '0;
      tail_byp   <= 1'b0;
      word_count <= '0;
    end else begin
      if (pop) begin
        word_count <= word_count + CNT_W'(1);
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            head_dat <= in_data;
            head_byp <= in_bypass;
            state    <= ONE;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            tail_dat <= in_data;
            tail_byp <= in_bypass;
            state    <= TWO;
          end else if (accept && pop) begin
            head_dat <= in_data;
            head_byp <= in_bypass;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_dat <= tail_dat;
            head_byp <= tail_byp;
            state    <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Lane 0 always carries the payload; the other lanes are zeroed in bypass.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < COPIES; k++) begin
      out_data[k*DATA_W +: DATA_W] = ((k == 0) || !head_byp) ? head_dat : '0;
    end
  end

endmodule

// File: tb/tb_tmr_coder_pipe.sv
// Purpose: self-checking bench for tmr_coder_pipe (3x16 with 4-bit counter, and 5x8 with 16-bit counter).
// Latency: checks the 1-cycle fill latency and 1 word/cycle streaming.
// Backpressure: exercises full-buffer hold-off, random out_ready and random in_valid drops.
module tb_tmr_coder_pipe;

  logic clk;
  logic rst_n;

  // Instance A: DATA_W=16, COPIES=3, CNT_W=4
  logic        a_in_valid;
  logic        a_in_ready;
  logic [15:0] a_in_data;
  logic        a_in_bypass;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [47:0] a_out_data;
  logic [3:0]  a_word_count;

  // Instance B: DATA_W=8, COPIES=5, CNT_W=16
  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_in_data;
  logic        b_in_bypass;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [39:0] b_out_data;
  logic [15:0] b_word_count;

  int checks = 0;
  int errors = 0;

  tmr_coder_pipe #(.DATA_W(16), .COPIES(3), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_bypass(a_in_bypass),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .word_count(a_word_count)
  );

  tmr_coder_pipe #(.DATA_W(8), .COPIES(5), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_bypass(b_in_bypass),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .word_count(b_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] enc3(input logic [16:0] w);
    if (w[0]) enc3 = {32'h0, w[16:1]};
    else      enc3 = {w[16:1], w[16:1], w[16:1]};
  endfunction

  initial begin
    logic [16:0] q[$];
    int sent, got, pops, cyc;
    bit seen17;

    rst_n = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'hFFFF; a_in_bypass = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_data = 8'hFF;    b_in_bypass = 1'b0; b_out_ready = 1'b1;

    // Reset held for two edges with in_valid high: nothing may be taken.
    step; step;
    rst_n = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_out_data", a_out_data, 48'h0);
    chk("rst_wc", a_word_count, 4'h0);
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_b_out_data", b_out_data, 40'h0);
    step;
    chk("idle_out_valid", a_out_valid, 1'b0);
    chk("idle_wc", a_word_count, 4'h0);

    // Single replicated word.
    a_in_valid = 1'b1; a_in_data = 16'hA5C3; a_in_bypass = 1'b0; a_out_ready = 1'b1;
    step;
    a_in_valid = 1'b0;
    chk("single_vld", a_out_valid, 1'b1);
    chk("single_data", a_out_data, 48'hA5C3_A5C3_A5C3);
    step;
    chk("single_done", a_out_valid, 1'b0);
    chk("single_wc", a_word_count, 4'd1);
    chk("idle_hold_data", a_out_data, 48'hA5C3_A5C3_A5C3);

    // Bypass word: lane 0 only.
    a_in_valid = 1'b1; a_in_data = 16'h1234; a_in_bypass = 1'b1;
    step;
    a_in_valid = 1'b0;
    chk("byp_vld", a_out_valid, 1'b1);
    chk("byp_data", a_out_data, 48'h0000_0000_1234);
    step;
    chk("byp_wc", a_word_count, 4'd2);

    // Back-pressure: fill both entries, third word held off.
    a_out_ready = 1'b0; a_in_bypass = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h0001;
    step;
    a_in_data = 16'h0002;
    chk("bp_rdy_one", a_in_ready, 1'b1);
    step;
    a_in_data = 16'h0003;
    chk("bp_rdy_full", a_in_ready, 1'b0);
    chk("bp_head", a_out_data, 48'h0001_0001_0001);
    step;
    chk("bp_still_full", a_in_ready, 1'b0);
    chk("bp_stable", a_out_data, 48'h0001_0001_0001);
    chk("bp_wc_hold", a_word_count, 4'd2);
    a_out_ready = 1'b1;
    step;
    chk("bp_second", a_out_data, 48'h0002_0002_0002);
    chk("bp_rdy_again", a_in_ready, 1'b1);
    step;
    a_in_valid = 1'b0;
    chk("bp_third", a_out_data, 48'h0003_0003_0003);
    chk("bp_third_vld", a_out_valid, 1'b1);
    step;
    chk("bp_drained", a_out_valid, 1'b0);
    chk("bp_wc", a_word_count, 4'd5);

    // Reset mid-operation with the buffer full.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'hAAAA;
    step;
    a_in_data = 16'hBBBB;
    step;
    a_in_valid = 1'b0;
    chk("mid_full", a_in_ready, 1'b0);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("mid_out_valid", a_out_valid, 1'b0);
    chk("mid_wc", a_word_count, 4'd0);
    chk("mid_out_data", a_out_data, 48'h0);
    chk("mid_in_ready", a_in_ready, 1'b1);
    a_out_ready = 1'b1;
    step;
    chk("mid_no_emit", a_out_valid, 1'b0);
    step;
    chk("mid_no_emit2", a_out_valid, 1'b0);

    // Instance B: five copies of eight bits.
    b_in_valid = 1'b1; b_in_data = 8'h3C; b_in_bypass = 1'b0; b_out_ready = 1'b1;
    step;
    b_in_data = 8'h5A; b_in_bypass = 1'b1;
    chk("b5_data", b_out_data, 40'h3C3C3C3C3C);
    chk("b5_wc0", b_word_count, 16'd0);
    step;
    b_in_valid = 1'b0;
    chk("b5_byp", b_out_data, 40'h000000005A);
    chk("b5_wc1", b_word_count, 16'd1);
    step;
    chk("b5_wc2", b_word_count, 16'd2);
    chk("b5_idle", b_out_valid, 1'b0);

    // Streaming with random in_valid/out_ready/bypass against a queue model.
    sent = 0; got = 0; pops = 0; cyc = 0; seen17 = 1'b0;
    while ((got < 1000) && (cyc < 20000)) begin
      if ((sent < 1000) && ($urandom_range(0, 3) != 0)) begin
        a_in_valid  = 1'b1;
        a_in_data   = 16'($urandom);
        a_in_bypass = 1'($urandom_range(0, 1));
      end else begin
        a_in_valid  = 1'b0;
        a_in_data   = 16'($urandom);
      end
      a_out_ready = ($urandom_range(0, 2) != 0);
      chk("s_in_ready", a_in_ready, (q.size() < 2));
      chk("s_out_valid", a_out_valid, (q.size() != 0));
      chk("s_wc", a_word_count, pops[3:0]);
      if ((pops == 17) && !seen17) begin
        chk("s_wc_17th", a_word_count, 4'd1);
        seen17 = 1'b1;
      end
      if (a_out_valid && a_out_ready && (q.size() > 0)) begin
        chk("s_data", a_out_data, enc3(q.pop_front()));
        pops++;
        got++;
      end
      if (a_in_valid && a_in_ready) begin
        q.push_back({a_in_data, a_in_bypass});
        sent++;
      end
      step;
      cyc++;
    end
    a_in_valid = 1'b0;
    chk("s_words_out", got, 1000);
    chk("s_words_in", sent, 1000);
    step;
    chk("s_final_wc", a_word_count, pops[3:0]);
    chk("s_final_idle", a_out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
